// File: rtl/drive_pkg.sv
// Shared constants for the drive command path: ASCII opcodes, clock rate,
// rate-shaping defaults and the queue controller state type.
package drive_pkg;

  localparam int CLK_HZ = 50_000_000;

  localparam logic [7:0] CMD_FWD   = 8'h46;  // "F"
  localparam logic [7:0] CMD_BACK  = 8'h42;  // "B"
  localparam logic [7:0] CMD_LEFT  = 8'h4C;  // "L"
  localparam logic [7:0] CMD_RIGHT = 8'h52;  // "R"
  localparam logic [7:0] CMD_STOP  = 8'h53;  // "S"

  // 100 ms repeat holdoff, 500 ms heartbeat
  localparam int HOLDOFF_DEFAULT   = CLK_HZ / 10;
  localparam int HEARTBEAT_DEFAULT = CLK_HZ / 2;

  typedef enum logic [1:0] {
    NO_CMD = 2'd0,
    ACTIVE = 2'd1,
    IDLE   = 2'd2
  } ctl_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_cmd_queue_fifo.sv
// First-word fall-through register FIFO with occupancy output; read data
// reads as zero while empty so the output is clean after reset.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage carries data only; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_cmd_queue.sv
// Command byte queue in front of uart_tx: drops fast repeats of the last
// command and re-sends it as a heartbeat when the link has gone quiet.
module uart_cmd_queue
  import drive_pkg::*;
#(
  parameter int DEPTH            = 8,
  parameter int HOLDOFF_CYCLES   = HOLDOFF_DEFAULT,
  parameter int HEARTBEAT_CYCLES = HEARTBEAT_DEFAULT,
  parameter int DEDUP_EN         = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic [7:0]             drop_count
);

  localparam int CNT_MAX = max_int(max_int(HOLDOFF_CYCLES, HEARTBEAT_CYCLES), 2);
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] HB_LAST   = CNT_W'(HEARTBEAT_CYCLES - 1);

  ctl_state_t       state;
  ctl_state_t       state_nxt;
  logic             last_valid;
  logic             hb_fire;
  logic [7:0]       last_byte;
  logic [CNT_W-1:0] holdoff_cnt;
  logic [CNT_W-1:0] idle_cnt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             discard;
  logic             in_push;
  logic             pop;
  logic             fifo_wr;
  logic [7:0]       fifo_wdata;

  assign in_ready   = ~fifo_full;
  assign out_valid  = ~fifo_empty;
  assign pop        = out_valid & out_ready;
  assign discard    = (DEDUP_EN != 0) && last_valid && (in_data == last_byte) &&
                      (holdoff_cnt != '0);
  assign in_push    = in_valid & in_ready & ~discard;
  assign fifo_wr    = in_push | hb_fire;
  assign fifo_wdata = in_push ? in_data : last_byte;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (fifo_wr),
    .wr_data (fifo_wdata),
    .rd_en   (pop),
    .rd_data (out_data),
    .level   (level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= NO_CMD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      NO_CMD:  if (in_push) state_nxt = ACTIVE;
      ACTIVE:  if (fifo_empty && !fifo_wr) state_nxt = IDLE;
      IDLE:    if (fifo_wr) state_nxt = ACTIVE;
      default: state_nxt = NO_CMD;
    endcase
  end

  // A real input byte always wins over a heartbeat due on the same cycle.
  always_comb begin
    last_valid = (state != NO_CMD);
    hb_fire    = (state == IDLE) && fifo_empty && (idle_cnt == HB_LAST) && !in_push;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_byte   <= 8'h00;
      holdoff_cnt <= '0;
      idle_cnt    <= '0;
      drop_count  <= 8'h00;
    end else begin
      if (in_push) begin
        last_byte   <= in_data;
        holdoff_cnt <= HOLD_LOAD;
      end else if (holdoff_cnt != '0) begin
        holdoff_cnt <= holdoff_cnt - 1'b1;
      end
      if (fifo_wr || pop)                idle_cnt <= '0;
      else if (last_valid && fifo_empty) idle_cnt <= idle_cnt + 1'b1;
      if (in_valid && !in_ready && drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_cmd_queue.sv
// Bench for uart_cmd_queue: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_uart_cmd_queue;
  import drive_pkg::*;

  localparam int DEPTH = 4;
  localparam int HOLD  = 8;
  localparam int HB    = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] level;
  logic [7:0] drop_count;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  byte unsigned mq[$];
  bit           m_lv = 1'b0;
  byte unsigned m_lb = 8'h00;
  int           m_hold = 0;
  int           m_idle = 0;
  int           m_drop = 0;
  byte unsigned seen[$];
  byte unsigned cmds[5];
  byte unsigned exp1[4];
  byte unsigned exp4[5];

  uart_cmd_queue #(
    .DEPTH(DEPTH), .HOLDOFF_CYCLES(HOLD), .HEARTBEAT_CYCLES(HB), .DEDUP_EN(1)
  ) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .level(level), .drop_count(drop_count)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int seen_at(input int i);
    if (i < seen.size()) return int'(seen[i]);
    return -1;
  endfunction

  // Reference model: the queue contents plus the dedup / heartbeat rules.
  always @(posedge clk) begin
    bit rdy, disc, pin, pp, hb;
    if (reset) begin
      mq.delete();
      m_lv = 1'b0; m_lb = 8'h00; m_hold = 0; m_idle = 0; m_drop = 0;
    end else begin
      rdy  = (mq.size() < DEPTH);
      disc = m_lv && (in_data == m_lb) && (m_hold > 0);
      pin  = in_valid && rdy && !disc;
      pp   = out_ready && (mq.size() > 0);
      hb   = !pin && m_lv && (mq.size() == 0) && (m_idle == HB - 1);
      if (in_valid && !rdy && m_drop < 255) m_drop++;
      if (pin || hb || pp) m_idle = 0;
      else if (m_lv && mq.size() == 0) m_idle++;
      if (pin) m_hold = HOLD - 1;
      else if (m_hold > 0) m_hold--;
      if (pp) void'(mq.pop_front());
      if (pin) begin
        mq.push_back(in_data);
        m_lb = in_data;
        m_lv = 1'b1;
      end else if (hb) begin
        mq.push_back(m_lb);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", int'(in_ready), int'(mq.size() < DEPTH));
      chk("level", int'(level), mq.size());
      chk("out_valid", int'(out_valid), int'(mq.size() != 0));
      if (mq.size() != 0) chk("out_data", int'(out_data), int'(mq[0]));
      chk("drop_count", int'(drop_count), m_drop);
      if (!reset && out_valid && out_ready) seen.push_back(out_data);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    tick(2);
    reset    = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n, ph;
    cmds = '{CMD_FWD, CMD_BACK, CMD_LEFT, CMD_RIGHT, CMD_STOP};
    exp1 = '{CMD_FWD, CMD_LEFT, CMD_RIGHT, CMD_STOP};
    exp4 = '{CMD_RIGHT, CMD_RIGHT, CMD_RIGHT, CMD_LEFT, CMD_LEFT};

    tick();
    do_reset();
    chk_en = 1'b1;
    chk("rst_level", int'(level), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_drop", int'(drop_count), 0);

    // Fill, overflow, saturate, drain in order
    push(CMD_FWD); push(CMD_LEFT); push(CMD_RIGHT); push(CMD_STOP);
    chk("full_level", int'(level), 4);
    chk("full_in_ready", int'(in_ready), 0);
    repeat (3) begin
      push(CMD_BACK);
      tick();
    end
    chk("drop3", int'(drop_count), 3);
    in_valid = 1'b1; in_data = CMD_BACK;
    tick(300);
    in_valid = 1'b0;
    chk("drop_sat", int'(drop_count), 255);
    seen.delete();
    out_ready = 1'b1;
    k = 0;
    while (out_valid && k < 20) begin tick(); k++; end
    out_ready = 1'b0;
    chk("drain_empty", int'(out_valid), 0);
    chk("drain_count", seen.size(), 4);
    for (int i = 0; i < 4; i++) chk("drain_order", seen_at(i), int'(exp1[i]));

    // Repeat suppression window
    do_reset();
    push(CMD_FWD);
    tick(2);
    push(CMD_FWD);
    chk("dedup_discard", int'(level), 1);
    tick(6);
    push(CMD_FWD);
    chk("dedup_expired", int'(level), 2);
    push(CMD_LEFT);
    chk("dedup_diff", int'(level), 3);
    chk("dedup_nodrop", int'(drop_count), 0);

    // Heartbeat timing and collision with a real byte
    do_reset();
    seen.delete();
    out_ready = 1'b1;
    push(CMD_RIGHT);
    for (int g = 0; g < 2; g++) begin
      k = 0;
      while (out_valid && k < 10) begin tick(); k++; end
      n = 0;
      while (!out_valid && n < 100) begin n++; tick(); end
      chk("hb_gap", n, HB);
    end
    k = 0;
    while (out_valid && k < 10) begin tick(); k++; end
    while (m_idle != HB - 1 && k < 100) begin tick(); k++; end
    push(CMD_LEFT);
    tick(40);
    out_ready = 1'b0;
    chk("hb_seen_count", seen.size(), 5);
    for (int i = 0; i < 5; i++) chk("hb_order", seen_at(i), int'(exp4[i]));

    // Concurrent push/pop across pointer wrap
    do_reset();
    seen.delete();
    push(CMD_FWD); push(CMD_LEFT);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h30 + 8'(i);
      tick();
      chk("pp_level", int'(level), 2);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("pp_count", seen.size(), 10);
    chk("pp_first", seen_at(0), int'(CMD_FWD));
    chk("pp_second", seen_at(1), int'(CMD_LEFT));
    for (int i = 2; i < 10; i++) chk("pp_order", seen_at(i), 8'h30 + i - 2);

    // Reset mid-drain clears everything and arms no heartbeat
    do_reset();
    push(CMD_STOP); push(CMD_BACK); push(CMD_FWD); push(CMD_RIGHT);
    push(CMD_LEFT);
    chk("s6_drop", int'(drop_count), 1);
    out_ready = 1'b1;
    tick();
    chk("s6_level3", int'(level), 3);
    reset = 1'b1;
    tick();
    reset = 1'b0; out_ready = 1'b0;
    chk("s6_level", int'(level), 0);
    chk("s6_valid", int'(out_valid), 0);
    chk("s6_drop0", int'(drop_count), 0);
    tick(60);
    chk("s6_no_hb", int'(out_valid), 0);

    // Randomized traffic: busy, sparse and quiet phases
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 599) == 0);
      ph = (c / 200) % 3;
      in_valid  = !reset && ($urandom_range(0, 99) < (ph == 0 ? 60 : (ph == 1 ? 10 : 1)));
      in_data   = cmds[$urandom_range(0, 4)];
      out_ready = ($urandom_range(0, 99) < (ph == 0 ? 30 : 80));
      tick();
    end
    reset = 1'b0; in_valid = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_queue.md
Name: uart_cmd_queue

Overview:
Buffering and rate-shaping stage between command_translator and uart_tx on the clk_50 domain. Accepts ASCII command bytes from the translator and queues them in a small FIFO. Suppresses rapid repeats of the same byte and re-sends the last command as a heartbeat when the link goes idle, so the base robot never starves. Presents bytes to uart_tx with a valid/ready handshake.

Parameters:
DEPTH, 8, FIFO entries; must be a power of 2 and at least 2
HOLDOFF_CYCLES, 5_000_000, window in which a repeat of the last accepted byte is discarded (100 ms at 50 MHz)
HEARTBEAT_CYCLES, 25_000_000, idle time after which the last accepted byte is re-queued (500 ms)
DEDUP_EN, 1, 1 enables repeat suppression; 0 queues every byte

Ports:
clk  in  1  system clock (clk_50)
reset  in  1  synchronous, active-high reset
in_data  in  8  ASCII byte from command_translator (ascii_out)
in_valid  in  1  byte offered (cmd_ready)
in_ready  out  1  queue can accept; equals ~full
out_data  out  8  byte to uart_tx (data_tx)
out_valid  out  1  byte available to uart_tx
out_ready  in  1  uart_tx idle (tx_ready); transfer when out_valid & out_ready
level  out  $clog2(DEPTH)+1  current FIFO occupancy
drop_count  out  8  saturating count of bytes lost to overflow

Behaviour:
- Reset (synchronous, active-high): level=0, out_valid=0, out_data=8'h00, in_ready=1, drop_count=0, last_valid=0, last_byte=8'h00, holdoff and idle counters=0, read and write pointers=0. Reset asserted mid-transfer discards all queued bytes.
- Storage is a register array. out_data is mem[rd_ptr] (first-word fall-through). out_valid=(level!=0). A push becomes visible at the output on the cycle after the push.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally at DEPTH.
- Push: in_valid & in_ready & ~discard. The write pointer and level advance.
- Pop: out_valid & out_ready. The read pointer advances and level decrements.
- Simultaneous push and pop: level is unchanged and both pointers advance.
- Push while full with a pop in the same cycle: in_ready is already 0, so the byte is not accepted.
- Overflow: in_valid & ~in_ready. The byte is dropped and drop_count increments, saturating at 255.
- Dedup (DEDUP_EN=1):
  - discard = last_valid & (in_data==last_byte) & (holdoff_cnt!=0).
  - A discarded byte is consumed: in_ready stays high and nothing is written.
  - Any accepted non-discarded byte sets last_byte=in_data, last_valid=1 and holdoff_cnt=HOLDOFF_CYCLES-1.
  - holdoff_cnt decrements to 0 and holds there.
  - A different byte is never discarded.
- Heartbeat:
  - idle_cnt resets to 0 on any push or pop. Otherwise it increments while level==0 & last_valid, and is held at 0 while last_valid==0.
  - When idle_cnt reaches HEARTBEAT_CYCLES-1 and no push occurs that cycle, last_byte is pushed and idle_cnt returns to 0.
  - An input push has priority over the heartbeat; a colliding heartbeat is skipped.
  - A heartbeat push does not touch holdoff_cnt.
- State machine for the heartbeat/dedup controller:
  - NO_CMD (last_valid=0) -> ACTIVE on first accepted byte.
  - ACTIVE -> IDLE when level==0.
  - IDLE -> ACTIVE on a push.
  - IDLE: on timeout, inject the heartbeat and move to ACTIVE.
- Widths: counters are sized with $clog2(max(HOLDOFF_CYCLES,HEARTBEAT_CYCLES)). Level never exceeds DEPTH.

Decomposition:
- Shared package drive_pkg holds: the ASCII command constants used by command_translator ("F","B","L","R","S") and a CLK_HZ=50_000_000 constant. HOLDOFF and HEARTBEAT defaults derive from CLK_HZ.
- One natural sub-module: sync_fifo (parameterised DEPTH/WIDTH, FWFT, level output). uart_cmd_queue wraps it and adds the dedup/heartbeat controller.

Test Plan:
All scenarios use DEPTH=4, HOLDOFF_CYCLES=8, HEARTBEAT_CYCLES=20 and out_ready held low unless stated.
1. Reset then push "F","L","R","S": level=4, in_ready=0. Release out_ready: output order is F,L,R,S, one per handshake, then out_valid=0.
2. With FIFO full, pulse in_valid with "B" 3 times: drop_count=3 and contents unchanged. Hold for 300 pushes: drop_count saturates at 255.
3. Push "F", then "F" again 3 cycles later: second byte consumed, level=1. Push "F" 10 cycles after the first accept: queued, level=2. Push "L" 1 cycle after an "F": queued.
4. out_ready=1, push "R", then no input: "R" transfers. Exactly 20 cycles after the pop, "R" reappears on out_valid, and repeats every ~20 idle cycles. In_valid coinciding with the timeout: the input byte wins and the heartbeat is skipped.
5. Simultaneous push and pop at level=2 over 10 cycles: level stays 2, data order preserved across pointer wrap.
6. Assert reset with level=3 mid-drain: next cycle level=0, out_valid=0, drop_count=0. No heartbeat occurs until a new byte is accepted.
